// File: rtl/pipelined_tree_multiplier.sv
// WIDTH x WIDTH -> 2*WIDTH multiplier (signed or unsigned per transaction) on valid/ready streams.
// Baugh-Wooley partial products, carry-save 3:2 tree, Kogge-Stone final adder, 1..4 register stages.
module pipelined_tree_multiplier #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o
);

  if (WIDTH < 2 || WIDTH > 32 || STAGES < 1 || STAGES > 4) begin : g_bad_param
    $fatal(1, "pipelined_tree_multiplier: WIDTH must be 2..32 and STAGES 1..4");
  end

  localparam int unsigned P  = 2 * WIDTH;
  localparam int unsigned NR = WIDTH + 1;  // WIDTH partial-product rows plus one correction row

  typedef logic [NR-1:0][P-1:0] rows_t;
  typedef logic [1:0][P-1:0]    pair_t;

  function automatic int unsigned next_rows(input int unsigned n);
    return (n > 2) ? (n / 3) * 2 + n % 3 : n;
  endfunction

  function automatic int unsigned num_levels(input int unsigned n);
    int unsigned m;
    int unsigned l;
    m = n;
    l = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (m > 2) begin
        m = next_rows(m);
        l++;
      end
    end
    return l;
  endfunction

  function automatic int unsigned rows_after(input int unsigned n, input int unsigned lv);
    int unsigned m;
    m = n;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < lv) m = next_rows(m);
    end
    return m;
  endfunction

  localparam int unsigned NLVL = num_levels(NR);
  localparam int unsigned MID  = NLVL / 2;
  localparam int unsigned NMID = rows_after(NR, MID);

  // Signed mode inverts the cross terms touching exactly one MSB and adds 2^W + 2^(2W-1).
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    rows_t r;
    logic  bit_pp;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        bit_pp = a[j] & b[i];
        if (s && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_pp = ~bit_pp;
        r[i][i+j] = bit_pp;
      end
    end
    if (s) begin
      r[WIDTH][WIDTH] = 1'b1;
      r[WIDTH][P-1]   = 1'b1;
    end
    return r;
  endfunction

  function automatic rows_t csa_reduce(input rows_t r_in, input int unsigned n_in,
                                       input int unsigned lv);
    rows_t       r;
    int unsigned n;
    int unsigned grp;
    int unsigned rem;
    logic [P-1:0] a, b, c;
    r = r_in;
    n = n_in;
    for (int unsigned l = 0; l < NLVL; l++) begin
      if (l < lv && n > 2) begin
        grp = n / 3;
        rem = n % 3;
        for (int unsigned g = 0; g < NR / 3; g++) begin
          if (g < grp) begin
            a = r[3*g];
            b = r[3*g+1];
            c = r[3*g+2];
            r[2*g]   = a ^ b ^ c;
            r[2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
          end
        end
        for (int unsigned k = 0; k < 2; k++) begin
          if (k < rem) r[2*grp+k] = r[3*grp+k];
        end
        n = 2 * grp + rem;
        for (int unsigned k = 0; k < NR; k++) begin
          if (k >= n) r[k] = '0;
        end
      end
    end
    return r;
  endfunction

  function automatic pair_t csa_final(input rows_t r_in, input int unsigned n_in,
                                      input int unsigned lv);
    rows_t r;
    r = csa_reduce(r_in, n_in, lv);
    return r[1:0];
  endfunction

  function automatic logic [P-1:0] prefix_add(input logic [P-1:0] a, input logic [P-1:0] b);
    logic [P-1:0] gg, pp, p;
    p  = a ^ b;
    gg = a & b;
    pp = p;
    // Descending index keeps lower positions at the previous level's values.
    for (int d = 1; d < int'(P); d = d * 2) begin
      for (int i = int'(P) - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    return p ^ {gg[P-2:0], 1'b0};
  endfunction

  logic         w_advance;
  rows_t        w_pp, w_a, w_mid, w_b;
  logic         w_a_v, w_b_v, w_c_v;
  pair_t        w_red, w_c;
  logic [P-1:0] w_sum;
  logic [P-1:0] r_o;
  logic         r_ov;

  assign w_advance = !r_ov | out_ready;
  assign in_ready  = w_advance;
  assign w_pp      = gen_pp(x, y, sgn);

  if (STAGES >= 2) begin : g_stage_a
    rows_t r_a;
    logic  r_a_v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a   <= '0;
        r_a_v <= 1'b0;
      end else if (w_advance) begin
        r_a   <= w_pp;
        r_a_v <= in_valid;
      end
    end
    assign w_a   = r_a;
    assign w_a_v = r_a_v;
  end else begin : g_pass_a
    assign w_a   = w_pp;
    assign w_a_v = in_valid;
  end

  assign w_mid = csa_reduce(w_a, NR, MID);

  if (STAGES >= 4) begin : g_stage_b
    rows_t r_b;
    logic  r_b_v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_b   <= '0;
        r_b_v <= 1'b0;
      end else if (w_advance) begin
        r_b   <= w_mid;
        r_b_v <= w_a_v;
      end
    end
    assign w_b   = r_b;
    assign w_b_v = r_b_v;
  end else begin : g_pass_b
    assign w_b   = w_mid;
    assign w_b_v = w_a_v;
  end

  assign w_red = csa_final(w_b, NMID, NLVL - MID);

  if (STAGES >= 3) begin : g_stage_c
    pair_t r_c;
    logic  r_c_v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_c   <= '0;
        r_c_v <= 1'b0;
      end else if (w_advance) begin
        r_c   <= w_red;
        r_c_v <= w_b_v;
      end
    end
    assign w_c   = r_c;
    assign w_c_v = r_c_v;
  end else begin : g_pass_c
    assign w_c   = w_red;
    assign w_c_v = w_b_v;
  end

  assign w_sum = prefix_add(w_c[0], w_c[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o  <= '0;
      r_ov <= 1'b0;
    end else if (w_advance) begin
      r_o  <= w_sum;
      r_ov <= w_c_v;
    end
  end

  assign out_valid = r_ov;
  assign o         = r_o;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Self-checking bench: main 8-bit/3-stage instance plus a WIDTH x STAGES sweep of instances,
// all checked against a plain-arithmetic product model.
module tb_pipelined_tree_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        sgn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipelined_tree_multiplier #(.WIDTH(8), .STAGES(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
  );

  // Sweep instances: index = 4*width_idx + stage_idx, WIDTH = 2 << width_idx, STAGES = stage_idx+1.
  logic        sw_valid  = 1'b0;
  logic        sw_sgn    = 1'b0;
  logic        sw_oready = 1'b1;
  logic [15:0] sw_x = '0;
  logic [15:0] sw_y = '0;
  logic [31:0] sw_o  [16];
  logic        sw_ov [16];
  logic        sw_ir [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_sweep
    localparam int unsigned W = 2 << (gi / 4);
    localparam int unsigned S = gi % 4 + 1;
    logic [2*W-1:0] w_o;
    logic           w_ov;
    logic           w_ir;
    pipelined_tree_multiplier #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid),
      .in_ready  (w_ir),
      .x         (sw_x[W-1:0]),
      .y         (sw_y[W-1:0]),
      .sgn       (sw_sgn),
      .out_valid (w_ov),
      .out_ready (sw_oready),
      .o         (w_o)
    );
    assign sw_o[gi]  = 32'(w_o);
    assign sw_ov[gi] = w_ov;
    assign sw_ir[gi] = w_ir;
  end

  // Interpret operands as integers of width w, multiply, keep the low 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    longint ua, ub, sa, sb, p;
    logic [63:0] mask;
    ua = longint'({32'b0, a}) & ((longint'(1) << w) - 1);
    ub = longint'({32'b0, b}) & ((longint'(1) << w) - 1);
    sa = (s && ua[w-1]) ? ua - (longint'(1) << w) : ua;
    sb = (s && ub[w-1]) ? ub - (longint'(1) << w) : ub;
    p = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (o !== 16'h0) $display("FAIL reset_o: got %h expected 0000", o);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (sw_ov[i] !== 1'b0) $display("FAIL reset_sweep_valid[%0d]: got %b expected 0", i, sw_ov[i]);
      else n_pass++;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [7:0]  tx [4];
    logic [7:0]  ty [4];
    logic        ts [4];
    logic [15:0] te [4];
    logic        exp_v;
    tx = '{8'hFF, 8'hFF, 8'h80, 8'h80};
    ty = '{8'hFF, 8'hFF, 8'h80, 8'h7F};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1};
    te = '{16'hFE01, 16'h0001, 16'h4000, 16'hC080};
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      in_valid = 1'b1;
      x = tx[v];
      y = ty[v];
      sgn = ts[v];
      for (int k = 1; k <= 3; k++) begin
        tick();
        in_valid = 1'b0;
        exp_v = (k == 3);
        n_checks++;
        if (out_valid !== exp_v)
          $display("FAIL directed_latency[%0d] edge %0d: got %b expected %b", v, k, out_valid, exp_v);
        else n_pass++;
      end
      n_checks++;
      if (o !== te[v]) $display("FAIL directed_product[%0d]: got %h expected %h", v, o, te[v]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [$];
    logic [15:0] e;
    int got, first, last;
    got = 0;
    first = -1;
    last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c < 50) begin
        in_valid = 1'b1;
        x = 8'($urandom);
        y = 8'($urandom);
        sgn = 1'($urandom);
        q.push_back(16'(ref_mul(32'(x), 32'(y), sgn, 8)));
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", c, in_ready);
        else n_pass++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        got++;
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL b2b_extra: got %h expected no output", o);
        end else begin
          e = q.pop_front();
          if (o !== e) $display("FAIL b2b_product #%0d: got %h expected %h", got, o, e);
          else n_pass++;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== 50) $display("FAIL b2b_count: got %0d expected 50", got);
    else n_pass++;
    n_checks++;
    if (last - first !== 49) $display("FAIL b2b_rate: got span %0d expected 49", last - first);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] got [$];
    logic [7:0]  tx [3];
    logic [7:0]  ty [3];
    logic [15:0] te [3];
    tx = '{8'd3, 8'd5, 8'd7};
    ty = '{8'd4, 8'd6, 8'd8};
    te = '{16'd12, 16'd30, 16'd56};
    out_ready = 1'b0;
    sgn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = tx[i];
      y = ty[i];
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL bp_full_valid: got %b expected 1", out_valid);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;  // must be refused while stalled
      x = 8'd9;
      y = 8'd9;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || o !== 16'd12)
        $display("FAIL bp_hold cycle %0d: got valid=%b o=%0d expected valid=1 o=12", c, out_valid, o);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) got.push_back(o);
      tick();
    end
    n_checks++;
    if (got.size() != 3) $display("FAIL bp_count: got %0d expected 3", got.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_checks++;
        if (got[i] !== te[i]) $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], te[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic exp_v;
    out_ready = 1'b1;
    sgn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = 8'(10 + i);
      y = 8'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mid_async_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (o !== 16'h0) $display("FAIL mid_async_o: got %h expected 0000", o);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_stale cycle %0d: got valid=%b o=%h expected 0", c, out_valid, o);
      else n_pass++;
    end
    in_valid = 1'b1;
    x = 8'd2;
    y = 8'd3;
    for (int k = 1; k <= 3; k++) begin
      tick();
      in_valid = 1'b0;
      exp_v = (k == 3);
      n_checks++;
      if (out_valid !== exp_v) $display("FAIL mid_next_latency edge %0d: got %b expected %b", k, out_valid, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (o !== 16'd6) $display("FAIL mid_next_product: got %0d expected 6", o);
    else n_pass++;
    tick();
  endtask

  task automatic test_sweep();
    logic [31:0] e;
    logic        exp_v;
    int          w, s;
    sw_oready = 1'b1;
    for (int it = 0; it < 512; it++) begin
      // Low nibbles are exhaustive over 256 pairs; upper bits random for the wider instances.
      sw_x = {12'($urandom), 4'(it)};
      sw_y = {12'($urandom), 4'(it >> 4)};
      sw_sgn = 1'(it >> 8);
      sw_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        tick();
        sw_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
          w = 2 << (i / 4);
          s = i % 4 + 1;
          exp_v = (k == s);
          n_checks++;
          if (sw_ov[i] !== exp_v || sw_ir[i] !== 1'b1)
            $display("FAIL sweep_latency W=%0d S=%0d edge %0d: got valid=%b ready=%b expected valid=%b ready=1",
                     w, s, k, sw_ov[i], sw_ir[i], exp_v);
          else n_pass++;
          if (exp_v) begin
            e = 32'(ref_mul(32'(sw_x), 32'(sw_y), sw_sgn, w));
            n_checks++;
            if (sw_o[i] !== e)
              $display("FAIL sweep_product W=%0d S=%0d x=%h y=%h sgn=%b: got %h expected %h",
                       w, s, sw_x, sw_y, sw_sgn, sw_o[i], e);
            else n_pass++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
